// File: rtl/sensor_conditioner_pkg.sv
// Shared types for the loop-detector conditioning front end of the
// traffic light controller.
package sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  typedef enum logic [1:0] {
    ABSENT   = 2'd0,
    QUAL_ON  = 2'd1,
    PRESENT  = 2'd2,
    QUAL_OFF = 2'd3
  } det_state_t;

  localparam int NUM_CHANNELS = 5;

  localparam int CH_E_STR  = 0;
  localparam int CH_W_STR  = 1;
  localparam int CH_E_LEFT = 2;
  localparam int CH_W_LEFT = 3;
  localparam int CH_NS     = 4;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Bundle of raw detector levels, light feedback and conditioned demand
// exchanged between the detector front end and its surroundings.
interface sensor_conditioner_if;
  import sensor_conditioner_pkg::*;

  logic e_str_raw;
  logic w_str_raw;
  logic e_left_raw;
  logic w_left_raw;
  logic ns_raw;

  colors e_str_light;
  colors w_str_light;
  colors e_left_light;
  colors w_left_light;
  colors ns_light;

  logic e_str_sensor;
  logic w_str_sensor;
  logic e_left_sensor;
  logic w_left_sensor;
  logic ns_sensor;

  logic [NUM_CHANNELS-1:0] stuck_fault;

  modport master (
    output e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw,
    output e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
    input  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
    input  stuck_fault
  );

  modport slave (
    input  e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw,
    input  e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
    output e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
    output stuck_fault
  );

endinterface

// File: rtl/sensor_conditioner_channel.sv
// One detector channel: two-flop synchroniser, edge debouncer, demand
// latch cleared by green, and a sticky stuck-occupied fault.
module sensor_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int STUCK_CYCLES    = 255
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  raw,
  input  colors light,
  output logic  sensor,
  output logic  fault
);

  localparam logic [3:0]  CNT_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] SCNT_LAST = 16'(STUCK_CYCLES - 1);
  localparam logic [15:0] SCNT_MAX  = 16'hFFFF;

  logic       s1_p0;
  logic       s2_p1;
  det_state_t state;
  det_state_t state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       call;
  logic [15:0] scnt;
  logic       present;

  // Synchronise the asynchronous loop level; only s2 is trusted.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
    end else begin
      s1_p0 <= raw;
      s2_p1 <= s1_p0;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ABSENT;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Debounce next state: a level change must persist DEBOUNCE_CYCLES samples.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ABSENT: begin
        if (s2_p1) begin
          state_next = QUAL_ON;
          cnt_next   = 4'd1;
        end
      end
      QUAL_ON: begin
        if (!s2_p1) begin
          state_next = ABSENT;
          cnt_next   = 4'd0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESENT;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      PRESENT: begin
        if (!s2_p1) begin
          state_next = QUAL_OFF;
          cnt_next   = 4'd1;
        end
      end
      QUAL_OFF: begin
        if (s2_p1) begin
          state_next = PRESENT;
        end else if (cnt == CNT_LAST) begin
          state_next = ABSENT;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        state_next = ABSENT;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign present = (state == PRESENT) || (state == QUAL_OFF);

  // Demand memory: held through yellow/red/all-red, cleared once green is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      call <= 1'b0;
    end else begin
      call <= (call | present) & (light != GREEN);
    end
  end

  // Stuck detector: saturating run length of steady occupancy, sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt  <= 16'd0;
      fault <= 1'b0;
    end else if (state == PRESENT) begin
      if (scnt != SCNT_MAX) begin
        scnt <= scnt + 16'd1;
      end
      if (scnt == SCNT_LAST) begin
        fault <= 1'b1;
      end
    end else begin
      scnt <= 16'd0;
    end
  end

  // A faulted channel recalls permanently so the approach is never starved.
  assign sensor = present | call | fault;

endmodule

// File: rtl/sensor_conditioner.sv
// Five independent detector channels feeding the traffic light controller.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int STUCK_CYCLES    = 255
) (
  input logic           clk,
  input logic           reset,
  sensor_conditioner_if.slave bus
);

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_e_str (
    .clk(clk), .reset(reset), .raw(bus.e_str_raw), .light(bus.e_str_light),
    .sensor(bus.e_str_sensor), .fault(bus.stuck_fault[CH_E_STR])
  );

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_w_str (
    .clk(clk), .reset(reset), .raw(bus.w_str_raw), .light(bus.w_str_light),
    .sensor(bus.w_str_sensor), .fault(bus.stuck_fault[CH_W_STR])
  );

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_e_left (
    .clk(clk), .reset(reset), .raw(bus.e_left_raw), .light(bus.e_left_light),
    .sensor(bus.e_left_sensor), .fault(bus.stuck_fault[CH_E_LEFT])
  );

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_w_left (
    .clk(clk), .reset(reset), .raw(bus.w_left_raw), .light(bus.w_left_light),
    .sensor(bus.w_left_sensor), .fault(bus.stuck_fault[CH_W_LEFT])
  );

  sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_ns (
    .clk(clk), .reset(reset), .raw(bus.ns_raw), .light(bus.ns_light),
    .sensor(bus.ns_sensor), .fault(bus.stuck_fault[CH_NS])
  );

endmodule
